// File: rtl/moore_seq_decoder.sv
// Receiver-side decoder for the 6-state Moore sequence encoder: tracks the encoder
// state from its 2-bit symbols, recovers the serial bits, packs them into words.
module moore_seq_decoder #(
  parameter int WORD_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sym_valid,
  input  logic [1:0]           sym,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [2:0]           state
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } phase_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } enc_state_t;

  // Stream handshake: sym is consumed on every rising edge where sym_valid=1;
  // there is no backpressure, and sym is ignored whenever sym_valid=0.

  phase_t                 phase_q, phase_d;
  enc_state_t             st_q, st_d;
  logic                   bit_q, bit_d;
  logic                   bit_valid_q, bit_valid_d;
  logic [WORD_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic                   dec_legal;
  logic                   dec_bit;
  enc_state_t             dec_next;
  logic [WORD_W-1:0]      shifted;

  // Symbol decode table for the tracked encoder state.
  always_comb begin
    dec_legal = 1'b0;
    dec_bit   = 1'b0;
    dec_next  = S0;
    case (st_q)
      S0: begin
        if (sym == 2'b01)      begin dec_legal = 1'b1; dec_bit = 1'b0; dec_next = S1; end
        else if (sym == 2'b11) begin dec_legal = 1'b1; dec_bit = 1'b1; dec_next = S2; end
      end
      S1: begin
        if (sym == 2'b10)      begin dec_legal = 1'b1; dec_bit = 1'b0; dec_next = S4; end
        else if (sym == 2'b00) begin dec_legal = 1'b1; dec_bit = 1'b1; dec_next = S5; end
      end
      S2: begin
        if (sym == 2'b01)      begin dec_legal = 1'b1; dec_bit = 1'b0; dec_next = S1; end
        else if (sym == 2'b10) begin dec_legal = 1'b1; dec_bit = 1'b1; dec_next = S3; end
      end
      S3: begin
        if (sym == 2'b01)      begin dec_legal = 1'b1; dec_bit = 1'b0; dec_next = S1; end
        else if (sym == 2'b11) begin dec_legal = 1'b1; dec_bit = 1'b1; dec_next = S0; end
      end
      S4: begin
        if (sym == 2'b10)      begin dec_legal = 1'b1; dec_bit = 1'b0; dec_next = S4; end
        else if (sym == 2'b00) begin dec_legal = 1'b1; dec_bit = 1'b1; dec_next = S5; end
      end
      S5: begin
        if (sym == 2'b10)      begin dec_legal = 1'b1; dec_bit = 1'b0; dec_next = S3; end
        else if (sym == 2'b11) begin dec_legal = 1'b1; dec_bit = 1'b1; dec_next = S0; end
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  assign shifted = {shift_q[WORD_W-2:0], dec_bit};

  always_comb begin
    phase_d      = phase_q;
    st_d         = st_q;
    bit_d        = bit_q;
    bit_valid_d  = 1'b0;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    if (sym_valid) begin
      case (phase_q)
        HUNT: begin
          // Only the S0 sync symbol is meaningful while hunting.
          if (sym == 2'b11) begin
            phase_d = TRACK;
            st_d    = S0;
          end
        end
        TRACK: begin
          if (dec_legal) begin
            st_d        = dec_next;
            bit_d       = dec_bit;
            bit_valid_d = 1'b1;
            shift_d     = shifted;
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
              word_d       = shifted;
              word_valid_d = 1'b1;
              cnt_d        = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            phase_d = HUNT;
            st_d    = S0;
            shift_d = '0;
            cnt_d   = '0;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          phase_d = HUNT;
          st_d    = S0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= HUNT;
      st_q         <= S0;
      bit_q        <= 1'b0;
      bit_valid_q  <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      phase_q      <= phase_d;
      st_q         <= st_d;
      bit_q        <= bit_d;
      bit_valid_q  <= bit_valid_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = bit_valid_q;
  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign locked     = (phase_q == TRACK);
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign state      = st_q;

endmodule

// File: tb/tb_moore_seq_decoder.sv
// Bench for moore_seq_decoder: directed scenarios plus randomized traffic, checked
// against an encoder-derived reference model and a word scoreboard.
module tb_moore_seq_decoder;

  localparam int WORD_W = 8;

  logic clk;
  logic rst;
  logic sym_valid;
  logic [1:0] sym;

  logic              bit_out, bit_valid, word_valid, locked, err;
  logic [WORD_W-1:0] word_out;
  logic [7:0]        err_cnt;
  logic [2:0]        state;

  logic              bit_out2, bit_valid2, word_valid2, locked2, err2;
  logic [WORD_W-1:0] word_out2;
  logic [1:0]        err_cnt2;
  logic [2:0]        state2;

  moore_seq_decoder #(.WORD_W(WORD_W), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym(sym),
    .bit_out(bit_out), .bit_valid(bit_valid), .word_out(word_out),
    .word_valid(word_valid), .locked(locked), .err(err),
    .err_cnt(err_cnt), .state(state)
  );

  moore_seq_decoder #(.WORD_W(WORD_W), .ERR_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym(sym),
    .bit_out(bit_out2), .bit_valid(bit_valid2), .word_out(word_out2),
    .word_valid(word_valid2), .locked(locked2), .err(err2),
    .err_cnt(err_cnt2), .state(state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Encoder description: next state per (state, bit) and the Moore symbol of each state.
  int         enc_next [6][2] = '{'{1, 2}, '{4, 5}, '{1, 3}, '{1, 0}, '{4, 5}, '{3, 0}};
  logic [1:0] enc_out  [6]    = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00};

  // reference model state
  logic              m_locked;
  int                m_state;
  logic              m_bit, m_bv, m_wv, m_err;
  logic [WORD_W-1:0] m_word;
  int                m_errs;
  int                bitq[$];
  logic [WORD_W-1:0] exp_q[$];

  logic [41:0] got_vec;
  assign got_vec = {state, locked, bit_valid, bit_out, word_valid, word_out, err, err_cnt,
                    state2, locked2, bit_valid2, bit_out2, word_valid2, word_out2, err2, err_cnt2};

  function automatic logic [41:0] exp_vec();
    logic [7:0] c8;
    logic [1:0] c2;
    c8 = (m_errs > 255) ? 8'd255 : 8'(m_errs);
    c2 = (m_errs > 3) ? 2'd3 : 2'(m_errs);
    return {3'(m_state), m_locked, m_bv, m_bit, m_wv, m_word, m_err, c8,
            3'(m_state), m_locked, m_bv, m_bit, m_wv, m_word, m_err, c2};
  endfunction

  function automatic logic [1:0] encode(input int st, input int b);
    return enc_out[enc_next[st][b]];
  endfunction

  task automatic model_step(input logic v, input logic [1:0] s, input logic r);
    int hit;
    hit   = -1;
    m_bv  = 1'b0;
    m_wv  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_state = 0; m_locked = 1'b0; m_bit = 1'b0; m_word = '0; m_errs = 0;
      bitq.delete();
    end else if (v) begin
      if (!m_locked) begin
        if (s == 2'b11) begin
          m_locked = 1'b1;
          m_state  = 0;
        end
      end else begin
        for (int b = 0; b < 2; b++)
          if (encode(m_state, b) == s) hit = b;
        if (hit >= 0) begin
          m_bit   = hit[0];
          m_bv    = 1'b1;
          m_state = enc_next[m_state][hit];
          bitq.push_back(hit);
          if (bitq.size() == WORD_W) begin
            for (int i = 0; i < WORD_W; i++) m_word[WORD_W-1-i] = bitq[i][0];
            m_wv = 1'b1;
            exp_q.push_back(m_word);
            bitq.delete();
          end
        end else begin
          m_err    = 1'b1;
          m_errs   = m_errs + 1;
          m_locked = 1'b0;
          m_state  = 0;
          bitq.delete();
        end
      end
    end
  endtask

  // driver: present one cycle of input, sample #1 after the edge, advance the model
  task automatic drive(input logic v, input logic [1:0] s, input logic r);
    sym_valid = v;
    sym       = s;
    rst       = r;
    @(posedge clk);
    #1;
    model_step(v, s, r);
    sym_valid = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b11, 1'b1);
    n_checks++;
    if (got_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_vec: got %h want %h", got_vec, exp_vec());
    end
    n_checks++;
    if ({state, locked, bit_valid, word_out, word_valid, err, err_cnt} !== 23'd0) begin
      n_fail++; $display("FAIL reset_vals: got state=%0d locked=%b cnt=%0d", state, locked, err_cnt);
    end
  endtask

  task automatic test_sync_ones();
    logic [1:0] syms [4]   = '{2'b11, 2'b11, 2'b10, 2'b11};
    logic [2:0] states [4] = '{3'd0, 3'd2, 3'd3, 3'd0};
    drive(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, syms[i], 1'b0);
      n_checks++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL sync_ones_vec[%0d]: got %h want %h", i, got_vec, exp_vec());
      end
      n_checks++;
      if ({locked, state, bit_valid, bit_out, err} !== {1'b1, states[i], (i != 0), (i != 0), 1'b0}) begin
        n_fail++; $display("FAIL sync_ones_dir[%0d]: got st=%0d bv=%b b=%b", i, state, bit_valid, bit_out);
      end
    end
  endtask

  task automatic test_zero_path();
    logic [1:0] syms [5]   = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b10};
    logic [2:0] states [5] = '{3'd1, 3'd4, 3'd4, 3'd5, 3'd3};
    logic       bits [5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b0, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, syms[i], 1'b0);
      n_checks++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL zero_path_vec[%0d]: got %h want %h", i, got_vec, exp_vec());
      end
      n_checks++;
      if ({state, bit_valid, bit_out, word_valid} !== {states[i], 1'b1, bits[i], 1'b0}) begin
        n_fail++; $display("FAIL zero_path_dir[%0d]: got st=%0d b=%b wv=%b", i, state, bit_out, word_valid);
      end
    end
  endtask

  task automatic send_b2(input string name);
    logic [1:0] syms [8] = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10};
    drive(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, syms[i], 1'b0);
      n_checks++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL %s_vec[%0d]: got %h want %h", name, i, got_vec, exp_vec());
      end
    end
    n_checks++;
    if ({word_valid, word_out, bit_valid} !== {1'b1, 8'hB2, 1'b1}) begin
      n_fail++; $display("FAIL %s_word: got wv=%b word=%h want 1 b2", name, word_valid, word_out);
    end
  endtask

  task automatic test_word_b2();
    drive(1'b0, 2'b00, 1'b1);
    send_b2("word_b2");
    drive(1'b0, 2'b00, 1'b0);
    n_checks++;
    if ({word_valid, word_out} !== {1'b0, 8'hB2}) begin
      n_fail++; $display("FAIL word_hold: got wv=%b word=%h want 0 b2", word_valid, word_out);
    end
  endtask

  task automatic test_error();
    logic [1:0] syms [4] = '{2'b11, 2'b10, 2'b11, 2'b00};
    drive(1'b0, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, syms[i], 1'b0);
      n_checks++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL error_vec[%0d]: got %h want %h", i, got_vec, exp_vec());
      end
    end
    n_checks++;
    if ({err, err_cnt, locked, bit_valid, word_valid, state} !== {1'b1, 8'd1, 3'b000, 3'd0}) begin
      n_fail++; $display("FAIL error_dir: got err=%b cnt=%0d locked=%b", err, err_cnt, locked);
    end
    send_b2("error_resync");
  endtask

  task automatic test_err_sat();
    int pulses;
    pulses = 0;
    drive(1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11, 1'b0);
      drive(1'b1, 2'b00, 1'b0);
      if (err2) pulses++;
      n_checks++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL err_sat_vec[%0d]: got %h want %h", i, got_vec, exp_vec());
      end
    end
    n_checks++;
    if ({pulses[3:0], err_cnt2, err_cnt} !== {4'd5, 2'd3, 8'd5}) begin
      n_fail++; $display("FAIL err_sat: got pulses=%0d cnt2=%0d cnt8=%0d want 5 3 5", pulses, err_cnt2, err_cnt);
    end
  endtask

  task automatic test_gap_reset();
    logic [1:0] syms [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    drive(1'b0, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 2'($urandom_range(0, 3)), 1'b0);
        n_checks++;
        if (got_vec !== exp_vec()) begin
          n_fail++; $display("FAIL gap_hold[%0d]: got %h want %h", i, got_vec, exp_vec());
        end
      end
      drive(1'b1, syms[i], 1'b0);
      n_checks++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL gap_sym[%0d]: got %h want %h", i, got_vec, exp_vec());
      end
    end
    drive(1'b1, 2'b10, 1'b1);
    n_checks++;
    if ({state, locked, bit_out, bit_valid, word_out, word_valid, err, err_cnt} !== 24'd0) begin
      n_fail++; $display("FAIL gap_reset: got st=%0d locked=%b word=%h", state, locked, word_out);
    end
    send_b2("gap_resync");
  endtask

  task automatic test_random();
    int pick;
    exp_q.delete();
    drive(1'b0, 2'b00, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      pick = $urandom_range(0, 99);
      if (pick < 1)       drive(1'b0, 2'b00, 1'b1);
      else if (pick < 20) drive(1'b0, 2'($urandom_range(0, 3)), 1'b0);
      else if (pick < 25) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      else if (!m_locked) drive(1'b1, ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3)), 1'b0);
      else                drive(1'b1, encode(m_state, $urandom_range(0, 1)), 1'b0);
      n_checks++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_vec[%0d]: got %h want %h", c, got_vec, exp_vec());
      end
      if (word_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL random_word[%0d]: got %h want none", c, word_out);
        end else if (word_out !== exp_q[0]) begin
          n_fail++; $display("FAIL random_word[%0d]: got %h want %h", c, word_out, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_leftover: got %0d words pending want 0", exp_q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    sym_valid = 1'b0;
    sym       = 2'b00;
    m_locked  = 1'b0; m_state = 0; m_bit = 1'b0; m_bv = 1'b0;
    m_wv      = 1'b0; m_err = 1'b0; m_word = '0; m_errs = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sync_ones();
    test_zero_path();
    test_word_b2();
    test_error();
    test_err_sat();
    test_gap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
